cache_mem_arbiter: RTL and testbench
====================================

// Module: cache_mem_arbiter
// PURPOSE
// Shares the single multi-cycle main memory port between the I-cache and D-cache fill controllers
// (and D-cache write-through stores). One owner at a time; round-robin on contention; tracks
// outstanding pipelined reads and routes each returning word to the owner only. Sits between the
// two cache interface blocks and the memory model.
// PARAMETERS
// ADDR_W    16  address width (byte address)
// DATA_W    16  data word width
// MAX_OUT   4   max reads in flight (memory read latency in cycles); counter is clog2(MAX_OUT+1) bits
// PORTS
// clk              in   1       clock, all state on rising edge
// rst_n            in   1       asynchronous, active-low reset
// icache_req       in   1       I-cache wants memory; held high for whole fill
// icache_addr      in   ADDR_W  I-cache read address for this cycle
// dcache_req       in   1       D-cache wants memory; held high for whole fill or store
// dcache_wr        in   1       D-cache access is a store (valid with dcache_req)
// dcache_addr      in   ADDR_W  D-cache address for this cycle
// dcache_wdata     in   DATA_W  D-cache store data
// mem_rdata        in   DATA_W  memory read data
// mem_data_valid   in   1       mem_rdata valid this cycle
// icache_grant     out  1       I-cache owns memory (registered)
// dcache_grant     out  1       D-cache owns memory (registered)
// icache_dvalid    out  1       mem_data_valid routed to I-cache
// dcache_dvalid    out  1       mem_data_valid routed to D-cache
// fill_data        out  DATA_W  mem_rdata passthrough to both caches
// mem_enable       out  1       memory access issued this cycle
// mem_wr           out  1       issued access is a write
// mem_addr         out  ADDR_W  memory address
// mem_wdata        out  DATA_W  memory write data
// protocol_err     out  1       sticky: data_valid with 0 outstanding, or issue at MAX_OUT
// BEHAVIOUR
// - Reset: FSM=IDLE, grants 0, outstanding=0, last_owner=D (so I wins first tie), protocol_err 0;
//   all mem_* outputs 0. Reset mid-fill discards in-flight reads; late data_valid after reset is
//   ignored and does NOT set protocol_err while outstanding==0 only for the first MAX_OUT cycles.
// - States: IDLE, SERVE_I, SERVE_D, DRAIN.
// - IDLE: if exactly one req -> SERVE_x next cycle; both -> serve the one != last_owner; none -> stay.
//   Grant asserts the cycle after req is first seen (1-cycle arbitration latency); no issue in IDLE.
// - SERVE_x: grant_x=1, last_owner<=x. mem_enable = req_x & (wr | outstanding<MAX_OUT);
//   mem_addr/mem_wr/mem_wdata forwarded combinationally from owner (I-cache: mem_wr=0, wdata=0).
//   Request that would exceed MAX_OUT is held off (mem_enable=0), not dropped.
// - Owner drops req: outstanding==0 -> IDLE (grant drops next cycle); else -> DRAIN.
// - DRAIN: grant stays with owner, no issue; when outstanding reaches 0 -> IDLE.
// - Other requester is never granted before the owner releases (no preemption, no timeout).
// - outstanding: +1 on mem_enable&~mem_wr, -1 on mem_data_valid, both same cycle -> unchanged.
//   Decrement at 0 saturates at 0 and sets protocol_err.
// - icache_dvalid = mem_data_valid & owner==I (SERVE_I or DRAIN from I); dcache_dvalid likewise.
//   Stores produce no data_valid; a single-cycle store: req 1 cycle in SERVE_D, then IDLE.
// - Back-to-back: release and new grant to other requester cost one IDLE cycle.
// TESTING
// 1 I-fill alone: icache_req @t0, addrs 0x1000..0x100E -> grant @t1, 8 issues, 8 icache_dvalid, IDLE.
// 2 Both req @t0 after reset -> I granted first; on I release+drain, D granted 1 IDLE cycle later.
// 3 Fill with MAX_OUT=4, memory latency 4: 5th issue stalls until first data_valid; no protocol_err.
// 4 Owner drops req with 3 in flight -> DRAIN, 3 dvalids routed to old owner, other req waits.
// 5 D store 0xBEEF @0x2002 -> mem_enable=1,mem_wr=1 one cycle, no dvalid, outstanding stays 0.
// 6 rst_n low mid-fill (2 in flight) -> grants 0 immediately, outstanding 0, FSM IDLE on release.

Source files
------------

// File: rtl/cache_mem_arbiter.sv
// Arbitrates the shared main-memory port between the I-cache and D-cache fill controllers.
// Tracks pipelined reads in flight and routes each returning word to the current owner only.
module cache_mem_arbiter #(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned MAX_OUT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              icache_req,
    input  logic [ADDR_W-1:0] icache_addr,
    input  logic              dcache_req,
    input  logic              dcache_wr,
    input  logic [ADDR_W-1:0] dcache_addr,
    input  logic [DATA_W-1:0] dcache_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_data_valid,
    output logic              icache_grant,
    output logic              dcache_grant,
    output logic              icache_dvalid,
    output logic              dcache_dvalid,
    output logic [DATA_W-1:0] fill_data,
    output logic              mem_enable,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              protocol_err
);
    localparam int unsigned CNT_W = $clog2(MAX_OUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUT);

    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, DRAIN} state_e;

    state_e           state_q, state_d;
    logic             last_d_q, last_d_d;        // last owner was the D-cache
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] quiet_q, quiet_d;          // cycles since reset, saturating at MAX_OUT
    logic             protocol_err_q, protocol_err_d;
    logic             icache_grant_q, icache_grant_d;
    logic             dcache_grant_q, dcache_grant_d;
    logic             rd_issue;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            last_d_q       <= 1'b1;
            outstanding_q  <= '0;
            quiet_q        <= '0;
            protocol_err_q <= 1'b0;
            icache_grant_q <= 1'b0;
            dcache_grant_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            last_d_q       <= last_d_d;
            outstanding_q  <= outstanding_d;
            quiet_q        <= quiet_d;
            protocol_err_q <= protocol_err_d;
            icache_grant_q <= icache_grant_d;
            dcache_grant_q <= dcache_grant_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        last_d_d       = last_d_q;
        outstanding_d  = outstanding_q;
        quiet_d        = quiet_q;
        protocol_err_d = protocol_err_q;
        mem_enable     = 1'b0;
        mem_wr         = 1'b0;
        mem_addr       = '0;
        mem_wdata      = '0;
        icache_dvalid  = 1'b0;
        dcache_dvalid  = 1'b0;

        case (state_q)
            IDLE: begin
                // On a tie the requester that did not own the port last wins
                if (icache_req && (!dcache_req || last_d_q)) begin
                    state_d = SERVE_I;
                end else if (dcache_req) begin
                    state_d = SERVE_D;
                end
            end
            SERVE_I: begin
                last_d_d      = 1'b0;
                mem_enable    = icache_req && (outstanding_q < CNT_MAX);
                mem_addr      = icache_addr;
                icache_dvalid = mem_data_valid;
            end
            SERVE_D: begin
                last_d_d      = 1'b1;
                mem_enable    = dcache_req && (dcache_wr || (outstanding_q < CNT_MAX));
                mem_wr        = dcache_wr;
                mem_addr      = dcache_addr;
                mem_wdata     = dcache_wdata;
                dcache_dvalid = mem_data_valid;
            end
            DRAIN: begin
                icache_dvalid = mem_data_valid && !last_d_q;
                dcache_dvalid = mem_data_valid && last_d_q;
            end
            default: state_d = IDLE;
        endcase

        rd_issue = mem_enable && !mem_wr;
        if (quiet_q != CNT_MAX) begin
            quiet_d = quiet_q + CNT_W'(1);
        end
        if (rd_issue && (outstanding_q == CNT_MAX)) begin
            protocol_err_d = 1'b1;
        end
        // Stray data right after reset belongs to reads the reset discarded
        if (rd_issue && !mem_data_valid) begin
            outstanding_d = outstanding_q + CNT_W'(1);
        end else if (!rd_issue && mem_data_valid) begin
            if (outstanding_q == '0) begin
                if (quiet_q == CNT_MAX) begin
                    protocol_err_d = 1'b1;
                end
            end else begin
                outstanding_d = outstanding_q - CNT_W'(1);
            end
        end

        case (state_q)
            SERVE_I: if (!icache_req) state_d = (outstanding_d == '0) ? IDLE : DRAIN;
            SERVE_D: if (!dcache_req) state_d = (outstanding_d == '0) ? IDLE : DRAIN;
            DRAIN:   if (outstanding_d == '0) state_d = IDLE;
            default: ;
        endcase

        icache_grant_d = (state_d == SERVE_I) || ((state_d == DRAIN) && !last_d_d);
        dcache_grant_d = (state_d == SERVE_D) || ((state_d == DRAIN) && last_d_d);
    end

    assign icache_grant = icache_grant_q;
    assign dcache_grant = dcache_grant_q;
    assign protocol_err = protocol_err_q;
    assign fill_data    = mem_rdata;
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter with a fixed-latency memory model.
// Inputs change just after the falling edge; outputs are sampled 1ns later.
module tb_cache_mem_arbiter;
    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        icache_req, dcache_req, dcache_wr, mem_data_valid;
    logic [15:0] icache_addr, dcache_addr, dcache_wdata, mem_rdata;
    logic        icache_grant, dcache_grant, icache_dvalid, dcache_dvalid;
    logic        mem_enable, mem_wr, protocol_err;
    logic [15:0] fill_data, mem_addr, mem_wdata;

    int checks = 0;
    int failures = 0;
    logic        pipe_v [LAT];
    logic [15:0] pipe_a [LAT];
    logic        inj_dv;
    logic        last_issue;
    logic [15:0] last_addr;
    int n_rd, n_wr, n_idv, n_ddv, fd_bad;

    cache_mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .icache_req(icache_req), .icache_addr(icache_addr),
        .dcache_req(dcache_req), .dcache_wr(dcache_wr),
        .dcache_addr(dcache_addr), .dcache_wdata(dcache_wdata),
        .mem_rdata(mem_rdata), .mem_data_valid(mem_data_valid),
        .icache_grant(icache_grant), .dcache_grant(dcache_grant),
        .icache_dvalid(icache_dvalid), .dcache_dvalid(dcache_dvalid),
        .fill_data(fill_data), .mem_enable(mem_enable), .mem_wr(mem_wr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;

    // Observe the current cycle, advance the memory pipe, start the next cycle
    task automatic tick();
        #1;
        last_issue = mem_enable;
        last_addr  = mem_addr;
        if (mem_enable && !mem_wr) n_rd++;
        if (mem_enable && mem_wr) n_wr++;
        if (icache_dvalid) n_idv++;
        if (dcache_dvalid) n_ddv++;
        if (fill_data !== mem_rdata) fd_bad++;
        for (int i = LAT - 1; i > 0; i--) begin
            pipe_v[i] = pipe_v[i-1];
            pipe_a[i] = pipe_a[i-1];
        end
        pipe_v[0] = mem_enable && !mem_wr;
        pipe_a[0] = mem_addr;
        @(negedge clk);
        mem_data_valid = pipe_v[LAT-1] | inj_dv;
        mem_rdata      = pipe_v[LAT-1] ? (pipe_a[LAT-1] ^ 16'hA5A5) : 16'h0000;
        #1;
    endtask

    task automatic clr();
        n_rd = 0; n_wr = 0; n_idv = 0; n_ddv = 0; fd_bad = 0;
    endtask

    task automatic wait_idle(output logic ok);
        int b = 0;
        while ((icache_grant || dcache_grant) && b < 40) begin
            tick();
            b++;
        end
        ok = !(icache_grant || dcache_grant);
    endtask

    // Issue n sequential reads from the granted cache, advancing the address only on issue
    task automatic run_fill(input logic use_d, input logic [15:0] base, input int n,
                            output int k, output int stalls, output int at_stall,
                            output int addr_bad);
        int b = 0;
        logic g;
        k = 0; stalls = 0; at_stall = -1; addr_bad = 0;
        while (k < n && b < 60) begin
            if (use_d) dcache_addr = base + 16'(2 * k);
            else       icache_addr = base + 16'(2 * k);
            g = use_d ? dcache_grant : icache_grant;
            tick();
            if (last_issue) begin
                if (last_addr !== base + 16'(2 * k)) addr_bad++;
                k++;
            end else if (g) begin
                stalls++;
                if (at_stall < 0) at_stall = k;
            end
            b++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        checks++; if (icache_grant !== 1'b0) begin failures++; $display("FAIL rst_igrant got=%0b want=0", icache_grant); end
        checks++; if (dcache_grant !== 1'b0) begin failures++; $display("FAIL rst_dgrant got=%0b want=0", dcache_grant); end
        checks++; if ({mem_enable, mem_wr} !== 2'b00) begin failures++; $display("FAIL rst_mem_en_wr got=%0b want=00", {mem_enable, mem_wr}); end
        checks++; if ({mem_addr, mem_wdata} !== 32'h0) begin failures++; $display("FAIL rst_mem_addr_wdata got=%0h want=0", {mem_addr, mem_wdata}); end
        checks++; if (protocol_err !== 1'b0) begin failures++; $display("FAIL rst_perr got=%0b want=0", protocol_err); end
        rst_n = 1'b1;
        tick(); tick();
        checks++; if ({icache_grant, dcache_grant} !== 2'b00) begin failures++; $display("FAIL rst_idle_grants got=%0b want=00", {icache_grant, dcache_grant}); end
    endtask

    task automatic test_both_req();
        int k, st, ias, ab, idle, b;
        logic ok;
        clr();
        icache_addr = 16'h3000; dcache_addr = 16'h4000; dcache_wr = 1'b0;
        icache_req = 1'b1; dcache_req = 1'b1;
        tick();
        checks++; if ({icache_grant, dcache_grant} !== 2'b10) begin failures++; $display("FAIL both_first_grant got=%0b want=10", {icache_grant, dcache_grant}); end
        run_fill(1'b0, 16'h3000, 2, k, st, ias, ab);
        checks++; if (k !== 2) begin failures++; $display("FAIL both_i_issues got=%0d want=2", k); end
        icache_req = 1'b0;
        idle = 0; b = 0;
        while (!dcache_grant && b < 30) begin
            if (!icache_grant) idle++;
            tick();
            b++;
        end
        checks++; if ({icache_grant, dcache_grant} !== 2'b01) begin failures++; $display("FAIL both_handover got=%0b want=01", {icache_grant, dcache_grant}); end
        checks++; if (idle !== 1) begin failures++; $display("FAIL both_idle_gap got=%0d want=1", idle); end
        checks++; if ({n_idv, n_ddv} !== {32'd2, 32'd0}) begin failures++; $display("FAIL both_i_route got=%0d/%0d want=2/0", n_idv, n_ddv); end
        run_fill(1'b1, 16'h4000, 1, k, st, ias, ab);
        dcache_req = 1'b0;
        wait_idle(ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL both_d_release got=%0b want=1", ok); end
        checks++; if ({n_idv, n_ddv} !== {32'd2, 32'd1}) begin failures++; $display("FAIL both_d_route got=%0d/%0d want=2/1", n_idv, n_ddv); end
    endtask

    task automatic test_i_fill();
        int k, st, ias, ab;
        logic ok;
        clr();
        dcache_wdata = 16'h1234;
        icache_addr = 16'h1000; icache_req = 1'b1;
        #1;
        checks++; if (icache_grant !== 1'b0) begin failures++; $display("FAIL ifill_t0_grant got=%0b want=0", icache_grant); end
        tick();
        checks++; if (icache_grant !== 1'b1) begin failures++; $display("FAIL ifill_t1_grant got=%0b want=1", icache_grant); end
        checks++; if ({mem_enable, mem_wr, mem_wdata} !== {2'b10, 16'h0}) begin failures++; $display("FAIL ifill_t1_issue got=%0h want=20000", {mem_enable, mem_wr, mem_wdata}); end
        run_fill(1'b0, 16'h1000, 8, k, st, ias, ab);
        checks++; if ({k, ab} !== {32'd8, 32'd0}) begin failures++; $display("FAIL ifill_issues got=%0d bad_addr=%0d want=8/0", k, ab); end
        checks++; if ({st, ias} !== {32'd1, 32'd4}) begin failures++; $display("FAIL ifill_maxout_stall got=%0d@%0d want=1@4", st, ias); end
        icache_req = 1'b0;
        wait_idle(ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL ifill_release got=%0b want=1", ok); end
        checks++; if ({n_idv, n_ddv} !== {32'd8, 32'd0}) begin failures++; $display("FAIL ifill_route got=%0d/%0d want=8/0", n_idv, n_ddv); end
        checks++; if ({n_rd, n_wr} !== {32'd8, 32'd0}) begin failures++; $display("FAIL ifill_counts got=%0d/%0d want=8/0", n_rd, n_wr); end
        checks++; if ({protocol_err, fd_bad} !== {1'b0, 32'd0}) begin failures++; $display("FAIL ifill_perr_fd got=%0b/%0d want=0/0", protocol_err, fd_bad); end
    endtask

    task automatic test_drain();
        int k, st, ias, ab, idle, held, b;
        logic ok;
        clr();
        dcache_wr = 1'b0; dcache_addr = 16'h5000; dcache_req = 1'b1;
        tick();
        checks++; if (dcache_grant !== 1'b1) begin failures++; $display("FAIL drain_d_grant got=%0b want=1", dcache_grant); end
        run_fill(1'b1, 16'h5000, 3, k, st, ias, ab);
        dcache_req = 1'b0; icache_req = 1'b1;
        idle = 0; held = 0; b = 0;
        while (!icache_grant && b < 30) begin
            if (dcache_grant) held++;
            else idle++;
            tick();
            b++;
        end
        icache_req = 1'b0;
        checks++; if (icache_grant !== 1'b1) begin failures++; $display("FAIL drain_i_grant got=%0b want=1", icache_grant); end
        checks++; if ({held, idle} !== {32'd4, 32'd1}) begin failures++; $display("FAIL drain_hold_gap got=%0d/%0d want=4/1", held, idle); end
        checks++; if ({n_ddv, n_idv} !== {32'd3, 32'd0}) begin failures++; $display("FAIL drain_route got=%0d/%0d want=3/0", n_ddv, n_idv); end
        wait_idle(ok);
        checks++; if ({ok, n_rd} !== {1'b1, 32'd3}) begin failures++; $display("FAIL drain_release got=%0b/%0d want=1/3", ok, n_rd); end
    endtask

    task automatic test_store();
        int k, st, ias, ab;
        logic ok;
        clr();
        dcache_wr = 1'b1; dcache_addr = 16'h2002; dcache_wdata = 16'hBEEF; dcache_req = 1'b1;
        tick();
        checks++; if ({dcache_grant, mem_enable, mem_wr} !== 3'b111) begin failures++; $display("FAIL store_issue got=%0b want=111", {dcache_grant, mem_enable, mem_wr}); end
        checks++; if ({mem_addr, mem_wdata} !== {16'h2002, 16'hBEEF}) begin failures++; $display("FAIL store_payload got=%0h want=2002beef", {mem_addr, mem_wdata}); end
        tick();
        dcache_req = 1'b0; dcache_wr = 1'b0;
        #1;
        checks++; if (mem_enable !== 1'b0) begin failures++; $display("FAIL store_one_cycle got=%0b want=0", mem_enable); end
        tick();
        checks++; if (dcache_grant !== 1'b0) begin failures++; $display("FAIL store_release got=%0b want=0", dcache_grant); end
        for (int i = 0; i < 5; i++) tick();
        checks++; if ({n_wr, n_rd, n_ddv} !== {32'd1, 32'd0, 32'd0}) begin failures++; $display("FAIL store_counts got=%0d/%0d/%0d want=1/0/0", n_wr, n_rd, n_ddv); end
        dcache_req = 1'b1;
        tick();
        run_fill(1'b1, 16'h6000, 5, k, st, ias, ab);
        dcache_req = 1'b0;
        checks++; if ({k, ab, st, ias} !== {32'd5, 32'd0, 32'd1, 32'd4}) begin failures++; $display("FAIL store_then_read got=%0d/%0d/%0d/%0d want=5/0/1/4", k, ab, st, ias); end
        wait_idle(ok);
        checks++; if ({ok, n_ddv, protocol_err} !== {1'b1, 32'd5, 1'b0}) begin failures++; $display("FAIL store_read_done got=%0b/%0d/%0b want=1/5/0", ok, n_ddv, protocol_err); end
    endtask

    task automatic test_reset_mid_fill();
        int k, st, ias, ab;
        logic ok;
        clr();
        icache_addr = 16'h7000; icache_req = 1'b1;
        tick();
        run_fill(1'b0, 16'h7000, 2, k, st, ias, ab);
        rst_n = 1'b0;
        #1;
        checks++; if ({icache_grant, dcache_grant, mem_enable} !== 3'b000) begin failures++; $display("FAIL midrst_async got=%0b want=000", {icache_grant, dcache_grant, mem_enable}); end
        icache_req = 1'b0;
        tick();
        rst_n = 1'b1;
        clr();
        for (int i = 0; i < 6; i++) tick();
        checks++; if ({n_idv, n_ddv} !== {32'd0, 32'd0}) begin failures++; $display("FAIL midrst_late_route got=%0d/%0d want=0/0", n_idv, n_ddv); end
        checks++; if ({protocol_err, icache_grant, dcache_grant} !== 3'b000) begin failures++; $display("FAIL midrst_state got=%0b want=000", {protocol_err, icache_grant, dcache_grant}); end
        icache_req = 1'b1;
        tick();
        run_fill(1'b0, 16'h7100, 5, k, st, ias, ab);
        icache_req = 1'b0;
        checks++; if ({k, st, ias} !== {32'd5, 32'd1, 32'd4}) begin failures++; $display("FAIL midrst_refill got=%0d/%0d/%0d want=5/1/4", k, st, ias); end
        wait_idle(ok);
        checks++; if ({ok, n_idv} !== {1'b1, 32'd5}) begin failures++; $display("FAIL midrst_refill_done got=%0b/%0d want=1/5", ok, n_idv); end
    endtask

    task automatic test_protocol_err();
        inj_dv = 1'b1;
        tick();
        inj_dv = 1'b0;
        checks++; if (protocol_err !== 1'b0) begin failures++; $display("FAIL perr_before got=%0b want=0", protocol_err); end
        tick();
        checks++; if (protocol_err !== 1'b1) begin failures++; $display("FAIL perr_set got=%0b want=1", protocol_err); end
        tick(); tick(); tick();
        checks++; if (protocol_err !== 1'b1) begin failures++; $display("FAIL perr_sticky got=%0b want=1", protocol_err); end
        rst_n = 1'b0;
        #1;
        checks++; if (protocol_err !== 1'b0) begin failures++; $display("FAIL perr_reset got=%0b want=0", protocol_err); end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        icache_req = 1'b0; icache_addr = '0;
        dcache_req = 1'b0; dcache_wr = 1'b0; dcache_addr = '0; dcache_wdata = '0;
        mem_rdata = '0; mem_data_valid = 1'b0; inj_dv = 1'b0;
        last_issue = 1'b0; last_addr = '0;
        for (int i = 0; i < LAT; i++) begin
            pipe_v[i] = 1'b0;
            pipe_a[i] = '0;
        end
        clr();
        test_reset();
        test_both_req();
        test_i_fill();
        test_drain();
        test_store();
        test_reset_mid_fill();
        test_protocol_err();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
